rc4_pin_loader: RTL and testbench
=================================

# rc4_pin_loader

Pad-side input front end that sits directly upstream of the `wrapped_rc4` cipher core. It recovers byte-wide commands strobed onto the user I/O pins by an off-chip host, decodes them into key-length, key-byte and data-byte transfers, and presents them to the core over valid/ready handshakes. Data bytes are buffered in a small FIFO; key bytes pass through a single holding register. It flags protocol violations and asserts back-pressure to the host.

## Interface
- `DATA_DEPTH`, 4: data FIFO entries, power of two, minimum 2.
- `wb_clk_i`  in  1  system clock; all logic on rising edge.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `pad_data_i`  in  8  host byte from io_in.
- `pad_cmd_i`  in  2  command: 00 data, 01 key length, 10 key byte, 11 session clear.
- `pad_strb_i`  in  1  host strobe; a rising edge marks one transfer.
- `pad_busy_o`  out  1  back-pressure to host (io_out).
- `err_o`  out  1  sticky protocol error (io_out).
- `key_start_o`  out  1  one-cycle pulse when a key length is accepted.
- `key_len_o`  out  9  key length, 1..256.
- `key_byte_o`  out  8  key byte to core.
- `key_valid_o`  out  1  key byte valid.
- `key_ready_i`  in  1  core accepts key byte.
- `data_o`  out  8  FIFO head byte.
- `data_valid_o`  out  1  FIFO non-empty.
- `data_ready_i`  in  1  core pops FIFO head.
- `sess_clr_o`  out  1  one-cycle pulse on session clear.

## Operation
- States: S_IDLE (no key), S_KEY (key bytes outstanding), S_READY (key complete, data accepted).
- Transfer event: rising edge of the conditioned strobe; data and cmd sampled from the same pipeline stage.
- Event while `pad_busy_o`=1: dropped, `err_o` set.
- cmd 01 (any state): `key_len_o` = byte, with 0 meaning 256; remaining count loaded; `key_start_o` pulses; go S_KEY. In S_KEY also sets `err_o` (restart). Any held key byte is discarded.
- cmd 10: in S_KEY load holding register, `key_valid_o`=1; cleared on `key_valid_o && key_ready_i`, which decrements the count; at count 0 go S_READY. In other states: dropped, `err_o` set.
- cmd 00: in S_READY push into FIFO. In other states: dropped, `err_o` set.
- cmd 11: flush FIFO and holding register, clear `err_o` and count, `sess_clr_o` pulse, go S_IDLE.
- `pad_busy_o` = holding register full OR FIFO full.
- FIFO: pop on `data_valid_o && data_ready_i`; simultaneous push and pop while full is impossible because busy blocks the push; push and pop when partly full leaves the count unchanged.
- Reset: every output is 0, state S_IDLE, FIFO empty.

## Timing
- With synchroniser: event occurs 3 cycles after the strobe rise at the pad (2 sync flops plus an edge flop).
- Without synchroniser: 1 cycle.
- Captured byte is visible on `key_byte_o` or `data_o` the cycle after the event. `key_start_o` and `sess_clr_o` assert that same cycle.
- Host timing requirements:
  - Hold data and cmd stable from ≥3 cycles before the strobe rise until the strobe falls.
  - Strobe high ≥3 cycles and low ≥3 cycles.
- `pad_busy_o` updates the cycle after the push or pop that changes it.
- Reset asserted mid-transfer aborts it immediately. Strobe edge detection restarts cleanly: a strobe already high at reset release is not an event.

## Configuration
- `RC4_LOADER_SYNC_EN` defined: a two-flop synchroniser is placed on `pad_data_i`, `pad_cmd_i` and `pad_strb_i`.
- Not defined: the pads are treated as synchronous to `wb_clk_i`, and only the edge-detect flop remains.

## Structure
- Package `rc4_loader_pkg`:
  - command encoding enum;
  - state enum;
  - `KEY_LEN_W` = 9;
  - default depth constant.
- Sub-module `rc4_loader_fifo`: parameterised synchronous FIFO with full/empty outputs, reused for the data path.

## Test plan
- Reset, then cmd 01 byte 0x03, three cmd 10 bytes 0x01/0x02/0x03 with `key_ready_i`=1:
  - `key_len_o`=3 and one `key_start_o` pulse;
  - three key handshakes;
  - state S_READY; `err_o`=0.
- cmd 01 byte 0x00: `key_len_o`=256.
- In S_READY, `data_ready_i`=0, send 5 data bytes 0xA0..0xA4 with DATA_DEPTH=4:
  - `pad_busy_o`=1 after the 4th byte;
  - the 5th byte is dropped and `err_o`=1;
  - the core later pops 0xA0..0xA3 in order.
- Data byte 0x55 in S_IDLE: dropped, `err_o`=1, `data_valid_o` stays 0. Then cmd 11: `err_o`=0 and `sess_clr_o` pulses.
- Strobe rise at cycle N: event effect visible at N+4 with the macro defined, N+2 without.
- Assert `wb_rst_ni` low mid key load: all outputs 0 asynchronously, state S_IDLE, FIFO empty.

Source files
------------

// File: rtl/rc4_loader_pkg.sv
// rc4_loader_pkg: shared command/state encodings and sizing for the RC4 pin loader.
package rc4_loader_pkg;
    typedef enum logic [1:0] {
        CMD_DATA  = 2'b00,
        CMD_KLEN  = 2'b01,
        CMD_KBYTE = 2'b10,
        CMD_CLR   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEY,
        S_READY
    } state_e;

    localparam int KEY_LEN_W      = 9;
    localparam int DEF_DATA_DEPTH = 4;

    // A zero length byte encodes the maximum key of 256 bytes.
    function automatic logic [KEY_LEN_W-1:0] key_len_of(input logic [7:0] b);
        return {b == 8'd0, b};
    endfunction
endpackage

// File: rtl/rc4_loader_fifo.sv
// rc4_loader_fifo: synchronous FIFO with flush, full/empty flags and a zeroed head when empty.
module rc4_loader_fifo
    import rc4_loader_pkg::*;
#(
    parameter int DEPTH = DEF_DATA_DEPTH,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr, r_rd;
    logic         w_push, w_pop;

    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + ONE;
            if (w_pop) r_rd <= r_rd + ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/rc4_pin_loader.sv
// rc4_pin_loader: decodes host pad strobes into key-length, key-byte and data transfers for the RC4 core.
// Define RC4_LOADER_SYNC_EN to add a two-flop synchroniser on the pad inputs.
module rc4_pin_loader
    import rc4_loader_pkg::*;
#(
    parameter int DATA_DEPTH = DEF_DATA_DEPTH
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [7:0]           pad_data_i,
    input  logic [1:0]           pad_cmd_i,
    input  logic                 pad_strb_i,
    output logic                 pad_busy_o,
    output logic                 err_o,
    output logic                 key_start_o,
    output logic [KEY_LEN_W-1:0] key_len_o,
    output logic [7:0]           key_byte_o,
    output logic                 key_valid_o,
    input  logic                 key_ready_i,
    output logic [7:0]           data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 sess_clr_o
);
    logic [10:0]          w_pad;
    logic                 r_strb_prev, r_evt;
    cmd_e                 r_cmd;
    logic [7:0]           r_byte;
    state_e               r_state, w_state_nx;
    logic [KEY_LEN_W-1:0] r_cnt, r_key_len;
    logic [7:0]           r_hold;
    logic                 r_hold_v, r_err, r_key_start, r_sess_clr;
    logic                 w_full, w_empty, w_pop, w_acc, w_kfire;
    logic                 w_klen, w_kbyte, w_data, w_clr, w_bad;

`ifdef RC4_LOADER_SYNC_EN
    logic [10:0] r_sync1, r_sync2;
    // Strobe bits reset high so a strobe held through reset release is not seen as a rise.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sync1 <= 11'h400;
            r_sync2 <= 11'h400;
        end else begin
            r_sync1 <= {pad_strb_i, pad_cmd_i, pad_data_i};
            r_sync2 <= r_sync1;
        end
    end
    assign w_pad = r_sync2;
`else
    assign w_pad = {pad_strb_i, pad_cmd_i, pad_data_i};
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_strb_prev <= 1'b1;
            r_evt       <= 1'b0;
            r_cmd       <= CMD_DATA;
            r_byte      <= 8'd0;
        end else begin
            r_strb_prev <= w_pad[10];
            r_evt       <= w_pad[10] & ~r_strb_prev;
            r_cmd       <= cmd_e'(w_pad[9:8]);
            r_byte      <= w_pad[7:0];
        end
    end

    assign pad_busy_o   = r_hold_v | w_full;
    assign data_valid_o = ~w_empty;
    assign w_pop        = data_valid_o & data_ready_i;
    assign w_kfire      = r_hold_v & key_ready_i;
    assign w_acc        = r_evt & ~pad_busy_o;
    assign w_klen       = w_acc && r_cmd == CMD_KLEN;
    assign w_kbyte      = w_acc && r_cmd == CMD_KBYTE && r_state == S_KEY;
    assign w_data       = w_acc && r_cmd == CMD_DATA && r_state == S_READY;
    assign w_clr        = w_acc && r_cmd == CMD_CLR;
    assign w_bad        = r_evt && (pad_busy_o
                        || (r_cmd == CMD_KLEN && r_state == S_KEY)
                        || (r_cmd == CMD_KBYTE && r_state != S_KEY)
                        || (r_cmd == CMD_DATA && r_state != S_READY));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_clr) w_state_nx = S_IDLE;
        else if (w_klen) w_state_nx = S_KEY;
        else if (w_kfire && r_cnt == 9'd1) w_state_nx = S_READY;
    end

    // Busy blocks every accepted event while a key byte is held, so load and handshake never coincide.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_key_len   <= '0;
            r_hold      <= 8'd0;
            r_hold_v    <= 1'b0;
            r_key_start <= 1'b0;
            r_sess_clr  <= 1'b0;
        end else begin
            r_key_start <= w_klen;
            r_sess_clr  <= w_clr;
            if (w_clr) begin
                r_err    <= 1'b0;
                r_cnt    <= '0;
                r_hold_v <= 1'b0;
            end else begin
                if (w_bad) r_err <= 1'b1;
                if (w_klen) begin
                    r_key_len <= key_len_of(r_byte);
                    r_cnt     <= key_len_of(r_byte);
                    r_hold_v  <= 1'b0;
                end else if (w_kbyte) begin
                    r_hold   <= r_byte;
                    r_hold_v <= 1'b1;
                end else if (w_kfire) begin
                    r_hold_v <= 1'b0;
                    r_cnt    <= r_cnt - 9'd1;
                end
            end
        end
    end

    assign err_o       = r_err;
    assign key_start_o = r_key_start;
    assign key_len_o   = r_key_len;
    assign key_byte_o  = r_hold;
    assign key_valid_o = r_hold_v;
    assign sess_clr_o  = r_sess_clr;

    rc4_loader_fifo #(
        .DEPTH (DATA_DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_flush (w_clr),
        .i_push  (w_data),
        .i_pop   (w_pop),
        .i_din   (r_byte),
        .o_dout  (data_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_rc4_pin_loader.sv
// tb_rc4_pin_loader: randomized scoreboard bench for rc4_pin_loader against a transfer-level model.
`timescale 1ns/1ps
module tb_rc4_pin_loader;
    localparam int DEPTH = 4;
`ifdef RC4_LOADER_SYNC_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 2;
`endif
    localparam int M_IDLE = 0, M_KEY = 1, M_READY = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] pad_data_i = '0;
    logic [1:0] pad_cmd_i = '0;
    logic       pad_strb_i = 1'b0, key_ready_i = 1'b0, data_ready_i = 1'b0;
    logic       pad_busy_o, err_o, key_start_o, key_valid_o, data_valid_o, sess_clr_o;
    logic [8:0] key_len_o;
    logic [7:0] key_byte_o, data_o;

    rc4_pin_loader #(.DATA_DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .pad_data_i(pad_data_i), .pad_cmd_i(pad_cmd_i),
        .pad_strb_i(pad_strb_i), .pad_busy_o(pad_busy_o), .err_o(err_o), .key_start_o(key_start_o),
        .key_len_o(key_len_o), .key_byte_o(key_byte_o), .key_valid_o(key_valid_o),
        .key_ready_i(key_ready_i), .data_o(data_o), .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i), .sess_clr_o(sess_clr_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int q_key[$], q_data[$], q_klen[$], q_clr[$];
    int m_st = M_IDLE, m_rem = 0;
    int m_err = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name, int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected no output", name, act);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid_o && key_ready_i) begin
                if (q_key.size() == 0) unexpected("key_byte", key_byte_o);
                else chk("key_byte", key_byte_o, q_key.pop_front());
            end
            if (data_valid_o && data_ready_i) begin
                if (q_data.size() == 0) unexpected("data_pop", data_o);
                else chk("data_pop", data_o, q_data.pop_front());
            end
            if (key_start_o) begin
                if (q_klen.size() == 0) unexpected("key_start", key_len_o);
                else chk("key_len", key_len_o, q_klen.pop_front());
            end
            if (sess_clr_o) begin
                if (q_clr.size() == 0) unexpected("sess_clr", 1);
                else void'(q_clr.pop_front());
            end
        end
    end

    // Reference behaviour at transfer granularity: decide fate of one host transfer.
    function automatic void model(int c, int b);
        int len;
        if (q_data.size() >= DEPTH || q_key.size() > 0) begin
            m_err = 1;
            return;
        end
        case (c)
            3: begin
                q_data.delete();
                m_err = 0;
                m_rem = 0;
                m_st = M_IDLE;
                q_clr.push_back(1);
            end
            1: begin
                if (m_st == M_KEY) m_err = 1;
                len = (b == 0) ? 256 : b;
                q_klen.push_back(len);
                m_rem = len;
                m_st = M_KEY;
            end
            2: begin
                if (m_st == M_KEY) begin
                    q_key.push_back(b);
                    m_rem--;
                    if (m_rem == 0) m_st = M_READY;
                end else m_err = 1;
            end
            default: begin
                if (m_st == M_READY) q_data.push_back(b);
                else m_err = 1;
            end
        endcase
    endfunction

    task automatic send(input int c, input int b, output int lat);
        pad_cmd_i = c[1:0];
        pad_data_i = b[7:0];
        repeat (3) @(posedge clk);
        #1;
        model(c, b);
        pad_strb_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) pad_strb_i = 1'b0;
            if ((key_start_o || sess_clr_o) && lat == 0) lat = i;
        end
        chk("err_after_tx", err_o, m_err);
        chk("busy_after_tx", pad_busy_o, (q_data.size() >= DEPTH || q_key.size() > 0) ? 1 : 0);
    endtask

    task automatic tx(input int c, input int b);
        int l;
        send(c, b, l);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, pad_busy_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_kstart"}, key_start_o, 0);
        chk({tag, "_klen"}, key_len_o, 0);
        chk({tag, "_kbyte"}, key_byte_o, 0);
        chk({tag, "_kvalid"}, key_valid_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_dvalid"}, data_valid_o, 0);
        chk({tag, "_sclr"}, sess_clr_o, 0);
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((q_data.size() || q_key.size() || q_klen.size() || q_clr.size()) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_pending"}, q_data.size() + q_key.size() + q_klen.size() + q_clr.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int l, r, c, b;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        key_ready_i = 1'b1;
        data_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(1, 3, l);
        chk("latency_klen", l, EXP_LAT);
        for (int i = 1; i <= 3; i++) tx(2, i);
        tx(0, 8'h11);
        tx(1, 0);
        send(3, 0, l);
        chk("latency_clr", l, EXP_LAT);

        tx(1, 1);
        tx(2, 8'h77);
        data_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx(0, 8'hA0 + i);
            if (i == 3) chk("busy_when_full", pad_busy_o, 1);
        end
        chk("err_after_overflow", err_o, 1);
        data_ready_i = 1'b1;
        drain("fifo_drain");
        chk("busy_after_drain", pad_busy_o, 0);

        tx(3, 0);
        tx(0, 8'h55);
        chk("idle_data_valid", data_valid_o, 0);
        tx(3, 0);
        chk("err_cleared", err_o, 0);

        for (int i = 0; i < 60; i++) begin
            data_ready_i = ($urandom_range(0, 2) != 0);
            repeat (6) @(posedge clk);
            #1;
            r = $urandom_range(0, 9);
            c = (r < 4) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            b = (c == 1) ? $urandom_range(1, 3) : $urandom_range(0, 255);
            tx(c, b);
        end
        data_ready_i = 1'b1;
        drain("random_drain");

        tx(3, 0);
        key_ready_i = 1'b0;
        tx(1, 4);
        tx(2, 8'h9C);
        chk("held_key_valid", key_valid_o, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        q_key.delete();
        q_data.delete();
        m_st = M_IDLE;
        m_rem = 0;
        m_err = 0;
        pad_cmd_i = 2'b01;
        pad_data_i = 8'd5;
        pad_strb_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_event_on_release_len", key_len_o, 0);
        chk("no_event_on_release_err", err_o, 0);
        pad_strb_i = 1'b0;
        key_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tx(0, 8'h42);
        chk("post_reset_idle_dvalid", data_valid_o, 0);
        tx(3, 0);
        drain("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
